// File: rtl/replay_trace_driver.sv
// replay_trace_driver: buffers cycle-stamped IO records from the sample loader,
// applies each record's inputs to the DUT on its stamped cycle, checks the
// masked DUT outputs one cycle later and reports exit/pass to the replay loop.
module replay_trace_driver #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 32,
  parameter int CYC_W   = 64,
  parameter int DEPTH   = 4,
  parameter int MAX_ERR = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rec_valid,
  output logic             rec_ready,
  input  logic [CYC_W-1:0] rec_cycle,
  input  logic [IN_W-1:0]  rec_in,
  input  logic [OUT_W-1:0] rec_expect,
  input  logic [OUT_W-1:0] rec_mask,
  input  logic             rec_last,
  output logic             dut_step,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic [CYC_W-1:0] cycles,
  output logic             mismatch,
  output logic [7:0]       err_count,
  output logic             exit,
  output logic             pass
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [7:0]       ERR_LIMIT = 8'(MAX_ERR);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [CYC_W-1:0] cyc;
    logic [IN_W-1:0]  din;
    logic [OUT_W-1:0] exp_v;
    logic [OUT_W-1:0] mask;
    logic             last;
  } rec_t;

  rec_t mem [DEPTH];

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IN_W-1:0]  dut_in_q, dut_in_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic [OUT_W-1:0] cmp_exp_q, cmp_exp_d, cmp_mask_q, cmp_mask_d;
  logic             mismatch_q, mismatch_d;
  logic [7:0]       err_q, err_d;
  logic             exit_q, exit_d, pass_q, pass_d;

  rec_t       head, wr_rec;
  logic       full, empty, push, pop, hit, stale, run_head;
  logic [1:0] err_add;
  logic [8:0] err_sum;

  assign head   = mem[rd_ptr_q];
  assign wr_rec = '{cyc: rec_cycle, din: rec_in, exp_v: rec_expect,
                    mask: rec_mask, last: rec_last};

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign rec_ready = !full && (state_q != DONE);
  assign push      = rec_valid && rec_ready;
  assign run_head  = (state_q == RUN) && !empty;
  assign hit       = run_head && (head.cyc == cycles_q);
  assign stale     = run_head && (head.cyc < cycles_q);
  assign pop       = hit || stale;
  assign dut_step  = run_head && !stale;

  assign dut_in    = dut_in_q;
  assign cycles    = cycles_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_q;
  assign exit      = exit_q;
  assign pass      = pass_q;

  // Record storage: written on every accepted record.
  // NOTE: the storage array has no reset; occupancy is tracked by the reset
  // pointers/count, so stale contents are never observed and the array can map
  // to plain RAM.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= wr_rec;
  end

  // Next-state: FIFO bookkeeping, head dispatch, compare stage, FSM and verdict.
  // NOTE: every signal written here gets its default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
    dut_in_d    = dut_in_q;
    cycles_d    = cycles_q;
    cmp_valid_d = cmp_valid_q;
    cmp_exp_d   = cmp_exp_q;
    cmp_mask_d  = cmp_mask_q;
    exit_d      = exit_q;
    pass_d      = pass_q;
    err_add     = 2'd0;

    if (state_q != DONE) begin
      // Compare the outputs produced by the inputs applied on the previous edge.
      if (cmp_valid_q && (((dut_out ^ cmp_exp_q) & cmp_mask_q) != '0))
        err_add = err_add + 2'd1;
      cmp_valid_d = 1'b0;
      if (hit) begin
        dut_in_d    = head.din;
        cmp_valid_d = 1'b1;
        cmp_exp_d   = head.exp_v;
        cmp_mask_d  = head.mask;
      end
      if (stale) err_add = err_add + 2'd1;
      if (dut_step) cycles_d = cycles_q + CYC_W'(1);
    end

    err_sum    = {1'b0, err_q} + {7'b0, err_add};
    err_d      = err_sum[8] ? 8'hFF : err_sum[7:0];
    mismatch_d = (err_add != 2'd0);

    case (state_q)
      IDLE:    if (push) state_d = RUN;
      RUN:     if (pop && head.last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      default: state_d = DONE;
    endcase
    // Too many errors: abandon the trace regardless of where it stands.
    if ((state_q != DONE) && (err_q >= ERR_LIMIT)) state_d = DONE;

    if ((state_d == DONE) && (state_q != DONE)) begin
      exit_d = 1'b1;
      pass_d = (err_d == 8'd0);
    end
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dut_in_q    <= '0;
      cycles_q    <= '0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_mask_q  <= '0;
      mismatch_q  <= 1'b0;
      err_q       <= '0;
      exit_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dut_in_q    <= dut_in_d;
      cycles_q    <= cycles_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_mask_q  <= cmp_mask_d;
      mismatch_q  <= mismatch_d;
      err_q       <= err_d;
      exit_q      <= exit_d;
      pass_q      <= pass_d;
    end
  end

endmodule
